// File: rtl/pong_pkg.sv
// Shared encodings and screen constants for the Pong game controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } game_state_t;

    localparam logic [9:0] MAX_X      = 10'd639;
    localparam logic [9:0] MAX_Y      = 10'd479;
    localparam logic [9:0] BAR_Y_RST  = 10'd204;
    localparam logic [9:0] BALL_X_RST = 10'd320;
    localparam logic [9:0] BALL_Y_RST = 10'd240;
    localparam logic [9:0] FRAME_Y    = 10'd481;
    localparam logic [9:0] FRAME_X    = 10'd0;

endpackage

// File: rtl/pong_frame_timer.sv
// Once-per-frame tick from the VGA scan position, plus the restart-delay frame counter.
module pong_frame_timer
    import pong_pkg::*;
#(
    parameter int TIMER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       load,
    output logic       frame_tick,
    output logic       zero
);

    localparam int TW = $clog2(TIMER_FRAMES + 1);

    logic          match;
    logic          match_q;
    logic [TW-1:0] timer;

    // pix_x stays at 0 for several clocks, so only the rising edge of the match counts
    assign match = (pix_y == FRAME_Y) && (pix_x == FRAME_X);
    assign zero  = (timer == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q    <= 1'b0;
            frame_tick <= 1'b0;
            timer      <= '0;
        end else begin
            match_q    <= match;
            frame_tick <= match && !match_q;
            if (load)
                timer <= TW'(TIMER_FRAMES);
            else if (frame_tick && !zero)
                timer <= timer - TW'(1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddle and ball motion, hit/miss detection and the game FSM.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WALL_X_R     = 35,
    parameter int BAR_X_L      = 600,
    parameter int BAR_X_R      = 603,
    parameter int BAR_Y_SIZE   = 72,
    parameter int BAR_V        = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_V       = 2,
    parameter int BALLS        = 3,
    parameter int TIMER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [1:0] btn,
    output logic       frame_tick,
    output logic [9:0] bar_y_t,
    output logic [9:0] ball_x_l,
    output logic [9:0] ball_y_t,
    output logic       ball_visible,
    output logic [1:0] balls_left,
    output logic [1:0] game_state,
    output logic       hit,
    output logic       miss
);

    localparam logic [9:0] WALL_R     = 10'(WALL_X_R);
    localparam logic [9:0] BAR_L      = 10'(BAR_X_L);
    localparam logic [9:0] BAR_R      = 10'(BAR_X_R);
    localparam logic [9:0] BAR_H1     = 10'(BAR_Y_SIZE - 1);
    localparam logic [9:0] BAR_STEP   = 10'(BAR_V);
    localparam logic [9:0] BALL_S1    = 10'(BALL_SIZE - 1);
    localparam logic [9:0] V_POS      = 10'(BALL_V);
    localparam logic [9:0] V_NEG      = 10'(-BALL_V);
    localparam logic [1:0] BALLS_INIT = 2'(BALLS);

    game_state_t state, state_n;
    logic [9:0]  bar_n, bx_n, by_n;
    logic [9:0]  x_delta, y_delta, dx_n, dy_n;
    logic [1:0]  balls_n;
    logic        hit_n, miss_n;
    logic        timer_load, timer_zero;
    logic [9:0]  ball_x_r, ball_y_b, bar_y_b;
    logic        hit_cond;

    pong_frame_timer #(
        .TIMER_FRAMES (TIMER_FRAMES)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .load       (timer_load),
        .frame_tick (frame_tick),
        .zero       (timer_zero)
    );

    assign game_state = state;

    always_comb begin
        state_n    = state;
        bar_n      = bar_y_t;
        bx_n       = ball_x_l;
        by_n       = ball_y_t;
        dx_n       = x_delta;
        dy_n       = y_delta;
        balls_n    = balls_left;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        timer_load = 1'b0;
        ball_x_r   = ball_x_l + BALL_S1;
        ball_y_b   = ball_y_t + BALL_S1;
        bar_y_b    = bar_y_t + BAR_H1;
        hit_cond   = (ball_x_r >= BAR_L) && (ball_x_r <= BAR_R) &&
                     (ball_y_b >= bar_y_t) && (ball_y_t <= bar_y_b);

        if (frame_tick) begin
            if (btn == 2'b10 && bar_y_b < MAX_Y - BAR_STEP)
                bar_n = bar_y_t + BAR_STEP;
            else if (btn == 2'b01 && bar_y_t > BAR_STEP)
                bar_n = bar_y_t - BAR_STEP;

            case (state)
                ST_NEWGAME: if (btn != 2'b00) state_n = ST_PLAY;
                ST_PLAY: begin
                    bx_n = ball_x_l + x_delta;
                    by_n = ball_y_t + y_delta;
                    if (ball_y_t <= 10'd1)
                        dy_n = V_POS;
                    else if (ball_y_b >= MAX_Y - 10'd1)
                        dy_n = V_NEG;
                    if (ball_x_l <= WALL_R)
                        dx_n = V_POS;
                    if (hit_cond) begin
                        dx_n  = V_NEG;
                        hit_n = 1'b1;
                    end else if (ball_x_r > MAX_X) begin
                        miss_n     = 1'b1;
                        balls_n    = balls_left - 2'd1;
                        timer_load = 1'b1;
                        state_n    = (balls_left == 2'd1) ? ST_OVER : ST_NEWBALL;
                    end
                end
                ST_NEWBALL: if (timer_zero && btn != 2'b00) state_n = ST_PLAY;
                ST_OVER: begin
                    if (timer_zero) begin
                        state_n = ST_NEWGAME;
                        balls_n = BALLS_INIT;
                    end
                end
                default: state_n = ST_NEWGAME;
            endcase

            // every serve starts from the centre heading down-right
            if (state_n == ST_PLAY && state != ST_PLAY) begin
                bx_n = BALL_X_RST;
                by_n = BALL_Y_RST;
                dx_n = V_POS;
                dy_n = V_POS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_NEWGAME;
            bar_y_t      <= BAR_Y_RST;
            ball_x_l     <= BALL_X_RST;
            ball_y_t     <= BALL_Y_RST;
            x_delta      <= V_POS;
            y_delta      <= V_POS;
            balls_left   <= BALLS_INIT;
            ball_visible <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
        end else begin
            state        <= state_n;
            bar_y_t      <= bar_n;
            ball_x_l     <= bx_n;
            ball_y_t     <= by_n;
            x_delta      <= dx_n;
            y_delta      <= dy_n;
            balls_left   <= balls_n;
            ball_visible <= (state_n == ST_PLAY);
            hit          <= hit_n;
            miss         <= miss_n;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: frame tick, paddle limits, hit, miss, serve and game over.
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset;
    logic [9:0] pix_x, pix_y;
    logic [1:0] btn;
    logic       frame_tick;
    logic [9:0] bar_y_t, ball_x_l, ball_y_t;
    logic       ball_visible;
    logic [1:0] balls_left, game_state;
    logic       hit, miss;

    int checks = 0;
    int passed = 0;
    logic hit_seen, miss_seen;
    int   tick_cnt;

    pong_game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .btn          (btn),
        .frame_tick   (frame_tick),
        .bar_y_t      (bar_y_t),
        .ball_x_l     (ball_x_l),
        .ball_y_t     (ball_y_t),
        .ball_visible (ball_visible),
        .balls_left   (balls_left),
        .game_state   (game_state),
        .hit          (hit),
        .miss         (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one frame: match coordinates held for two clocks, then two idle clocks
    task automatic frame();
        hit_seen = 1'b0; miss_seen = 1'b0; tick_cnt = 0;
        pix_y = 10'd481; pix_x = 10'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin pix_y = 10'd100; pix_x = 10'd5; end
            hit_seen  = hit_seen | hit;
            miss_seen = miss_seen | miss;
            tick_cnt  = tick_cnt + int'(frame_tick);
        end
    endtask

    task automatic test_reset(input string tag);
        reset = 1'b1; btn = 2'b00; pix_y = 10'd100; pix_x = 10'd5;
        @(posedge clk); #1;
        checks++; if (bar_y_t !== 10'd204) $display("FAIL %s bar_y_t: got %0d want 204", tag, bar_y_t); else passed++;
        checks++; if (ball_x_l !== 10'd320) $display("FAIL %s ball_x_l: got %0d want 320", tag, ball_x_l); else passed++;
        checks++; if (ball_y_t !== 10'd240) $display("FAIL %s ball_y_t: got %0d want 240", tag, ball_y_t); else passed++;
        checks++; if (ball_visible !== 1'b0) $display("FAIL %s ball_visible: got %0b want 0", tag, ball_visible); else passed++;
        checks++; if (balls_left !== 2'd3) $display("FAIL %s balls_left: got %0d want 3", tag, balls_left); else passed++;
        checks++; if (game_state !== 2'b00) $display("FAIL %s game_state: got %0b want 00", tag, game_state); else passed++;
        checks++; if ({frame_tick, hit, miss} !== 3'b000) $display("FAIL %s pulses: got %03b want 000", tag, {frame_tick, hit, miss}); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_frame_tick();
        int cnt, first;
        cnt = 0;
        pix_y = 10'd481; pix_x = 10'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) first = int'(frame_tick);
            cnt += int'(frame_tick);
        end
        checks++; if (first !== 1) $display("FAIL tick_latency: got %0d want 1", first); else passed++;
        checks++; if (cnt !== 1) $display("FAIL tick_once: got %0d want 1", cnt); else passed++;
        cnt = 0;
        pix_y = 10'd480; pix_x = 10'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cnt += int'(frame_tick);
        end
        checks++; if (cnt !== 0) $display("FAIL tick_row480: got %0d want 0", cnt); else passed++;
        pix_y = 10'd100; pix_x = 10'd5;
        @(posedge clk); #1;
        checks++; if (game_state !== 2'b00) $display("FAIL tick_idle_state: got %0b want 00", game_state); else passed++;
    endtask

    task automatic test_paddle();
        test_reset("paddle_rst");
        btn = 2'b11;
        frame(); frame();
        checks++; if (bar_y_t !== 10'd204) $display("FAIL paddle_both: got %0d want 204", bar_y_t); else passed++;
        checks++; if (game_state !== 2'b01) $display("FAIL paddle_start: got %0b want 01", game_state); else passed++;
        btn = 2'b10; frame();
        checks++; if (bar_y_t !== 10'd208) $display("FAIL paddle_down: got %0d want 208", bar_y_t); else passed++;
        btn = 2'b01;
        repeat (50) frame();
        checks++; if (bar_y_t !== 10'd8) $display("FAIL paddle_up50: got %0d want 8", bar_y_t); else passed++;
        frame();
        checks++; if (bar_y_t !== 10'd4) $display("FAIL paddle_top: got %0d want 4", bar_y_t); else passed++;
        repeat (10) frame();
        checks++; if (bar_y_t !== 10'd4) $display("FAIL paddle_top_hold: got %0d want 4", bar_y_t); else passed++;
    endtask

    task automatic test_hit();
        int n;
        test_reset("hit_rst");
        btn = 2'b10;
        n = 0;
        do begin frame(); n++; end while (!hit_seen && !miss_seen && n < 300);
        checks++; if (n !== 139 || !hit_seen) $display("FAIL hit_frame: got frame %0d hit %0b want frame 139 hit 1", n, hit_seen); else passed++;
        checks++; if (bar_y_t !== 10'd404) $display("FAIL paddle_bottom: got %0d want 404", bar_y_t); else passed++;
        checks++; if ({ball_x_l, ball_y_t} !== {10'd596, 10'd432}) $display("FAIL hit_pos: got (%0d,%0d) want (596,432)", ball_x_l, ball_y_t); else passed++;
        frame(); frame();
        checks++; if (ball_x_l !== 10'd592 || !hit_seen) $display("FAIL hit_repeat: got x %0d hit %0b want x 592 hit 1", ball_x_l, hit_seen); else passed++;
        frame();
        checks++; if (ball_x_l !== 10'd590 || hit_seen) $display("FAIL hit_leave: got x %0d hit %0b want x 590 hit 0", ball_x_l, hit_seen); else passed++;
        frame();
        checks++; if (ball_x_l !== 10'd588) $display("FAIL ball_left_move: got %0d want 588", ball_x_l); else passed++;
        checks++; if (game_state !== 2'b01 || ball_visible !== 1'b1) $display("FAIL hit_play: got state %0b vis %0b want 01 1", game_state, ball_visible); else passed++;
    endtask

    task automatic test_miss_newball();
        int n;
        test_reset("miss_rst");
        btn = 2'b01;
        n = 0;
        do begin frame(); n++; end while (!miss_seen && n < 300);
        checks++; if (n !== 159 || hit_seen) $display("FAIL miss_frame: got frame %0d hit %0b want frame 159 hit 0", n, hit_seen); else passed++;
        checks++; if (game_state !== 2'b10 || balls_left !== 2'd2) $display("FAIL miss_newball: got state %0b balls %0d want 10 2", game_state, balls_left); else passed++;
        checks++; if (ball_visible !== 1'b0) $display("FAIL miss_hidden: got %0b want 0", ball_visible); else passed++;
        repeat (120) frame();
        checks++; if (game_state !== 2'b10) $display("FAIL newball_wait: got %0b want 10", game_state); else passed++;
        btn = 2'b00; frame();
        checks++; if (game_state !== 2'b10) $display("FAIL newball_nobtn: got %0b want 10", game_state); else passed++;
        btn = 2'b01; frame();
        checks++; if (game_state !== 2'b01 || ball_visible !== 1'b1) $display("FAIL newball_serve: got state %0b vis %0b want 01 1", game_state, ball_visible); else passed++;
        checks++; if ({ball_x_l, ball_y_t} !== {10'd320, 10'd240}) $display("FAIL serve_pos: got (%0d,%0d) want (320,240)", ball_x_l, ball_y_t); else passed++;
    endtask

    task automatic test_game_over();
        int n;
        n = 0;
        do begin frame(); n++; end while (!miss_seen && n < 300);
        checks++; if (n !== 158 || balls_left !== 2'd1 || game_state !== 2'b10) $display("FAIL miss2: got frame %0d balls %0d state %0b want 158 1 10", n, balls_left, game_state); else passed++;
        n = 0;
        do begin frame(); n++; end while (game_state != 2'b01 && n < 300);
        checks++; if (n !== 121) $display("FAIL serve3_frame: got %0d want 121", n); else passed++;
        n = 0;
        do begin frame(); n++; end while (!miss_seen && n < 300);
        checks++; if (n !== 158 || game_state !== 2'b11 || balls_left !== 2'd0) $display("FAIL over: got frame %0d state %0b balls %0d want 158 11 0", n, game_state, balls_left); else passed++;
        checks++; if (ball_visible !== 1'b0) $display("FAIL over_hidden: got %0b want 0", ball_visible); else passed++;
        repeat (120) frame();
        checks++; if (game_state !== 2'b11) $display("FAIL over_wait: got %0b want 11", game_state); else passed++;
        frame();
        checks++; if (game_state !== 2'b00 || balls_left !== 2'd3) $display("FAIL over_newgame: got state %0b balls %0d want 00 3", game_state, balls_left); else passed++;
    endtask

    initial begin
        reset = 1'b1; btn = 2'b00; pix_x = 10'd5; pix_y = 10'd100;
        repeat (2) @(posedge clk);
        #1;
        test_reset("por");
        test_frame_tick();
        test_paddle();
        test_hit();
        test_reset("mid_play");
        test_miss_newball();
        test_game_over();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
